// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S frame arbiter.
// Holds the FSM state type, the mode encodings and the statistics counter width.
// Imported by the grant selector and the top level.
package i2s_pkg;

    localparam int AUDIO_DW_DEF = 32;
    localparam int UCNT_W       = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic MODE_RR   = 1'b0;
    localparam logic MODE_PRIO = 1'b1;

endpackage

// File: rtl/i2s_rr_arb.sv
// Combinational grant selection: round-robin with burst hold, or fixed priority.
// Ports: active gates all grants; valid/ptr/burst_cnt/mode in, one-hot-or-zero grant out.
// Zero latency; a grant is only ever raised on a valid source.
module i2s_rr_arb
    import i2s_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int BURST   = 2
) (
    input  logic               active,
    input  logic               mode,
    input  logic [NUM_SRC-1:0] valid,
    input  logic [2:0]         ptr,
    input  logic [3:0]         burst_cnt,
    output logic [NUM_SRC-1:0] grant
);

    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        if (active) begin
            if (mode == MODE_PRIO) begin
                for (int i = 0; i < NUM_SRC; i++) begin
                    if (!found && valid[i]) begin
                        grant[i] = 1'b1;
                        found    = 1'b1;
                    end
                end
            end else begin
                // burst_cnt == 0 means nobody currently holds the grant (after
                // reset or an underrun), so the pointer source gets no hold.
                for (int i = 0; i < NUM_SRC; i++) begin
                    if (i == int'(ptr) && valid[i] && burst_cnt != 4'd0 &&
                        int'(burst_cnt) < BURST) begin
                        grant[i] = 1'b1;
                        found    = 1'b1;
                    end
                end
                // Search upward from ptr+1; ptr itself comes last.
                for (int k = 1; k <= NUM_SRC; k++) begin
                    if (!found && valid[(int'(ptr) + k) % NUM_SRC]) begin
                        grant[(int'(ptr) + k) % NUM_SRC] = 1'b1;
                        found = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/i2s_frame_arbiter.sv
// Frame-rate scheduler sharing one I2S transmitter among NUM_SRC sources.
// Ports: lrclk/rst; enable, mode, clr_stats; per-source valid/left/right in,
// src_ready out; registered left_chan/right_chan, chan_valid, cur_src, underrun_cnt.
// One decision per frame; accepted pair appears one lrclk edge later.
module i2s_frame_arbiter
    import i2s_pkg::*;
#(
    parameter int AUDIO_DW      = AUDIO_DW_DEF,
    parameter int NUM_SRC       = 4,
    parameter int BURST         = 2,
    parameter bit UNDERRUN_HOLD = 1'b0
) (
    input  logic                        lrclk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic                        mode,
    input  logic                        clr_stats,
    input  logic [NUM_SRC-1:0]          src_valid,
    input  logic [NUM_SRC*AUDIO_DW-1:0] src_left,
    input  logic [NUM_SRC*AUDIO_DW-1:0] src_right,
    output logic [NUM_SRC-1:0]          src_ready,
    output logic [AUDIO_DW-1:0]         left_chan,
    output logic [AUDIO_DW-1:0]         right_chan,
    output logic                        chan_valid,
    output logic [2:0]                  cur_src,
    output logic [UCNT_W-1:0]           underrun_cnt
);

    state_t                state;
    state_t                next_state;
    logic [2:0]            ptr;
    logic [3:0]            burst_cnt;
    logic [NUM_SRC-1:0]    grant;
    logic                  run_en;
    logic                  xfer;
    logic                  underrun;
    logic [2:0]            win_idx;
    logic [AUDIO_DW-1:0]   win_left;
    logic [AUDIO_DW-1:0]   win_right;

    assign run_en   = (state == RUN) && enable;
    assign xfer     = |(grant & src_valid);
    assign underrun = run_en && !(|src_valid);
    assign src_ready = grant;

    i2s_rr_arb #(
        .NUM_SRC (NUM_SRC),
        .BURST   (BURST)
    ) u_arb (
        .active    (run_en),
        .mode      (mode),
        .valid     (src_valid),
        .ptr       (ptr),
        .burst_cnt (burst_cnt),
        .grant     (grant)
    );

    always_comb begin
        win_idx   = 3'd0;
        win_left  = '0;
        win_right = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant[i]) begin
                win_idx   = 3'(i);
                win_left  = src_left[i*AUDIO_DW +: AUDIO_DW];
                win_right = src_right[i*AUDIO_DW +: AUDIO_DW];
            end
        end
    end

    always_ff @(posedge lrclk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (enable)  next_state = RUN;
            RUN:     if (!enable) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge lrclk or negedge rst) begin
        if (!rst) begin
            left_chan    <= '0;
            right_chan   <= '0;
            chan_valid   <= 1'b0;
            cur_src      <= 3'd0;
            ptr          <= 3'(NUM_SRC - 1);
            burst_cnt    <= 4'd0;
            underrun_cnt <= '0;
        end else begin
            if (!run_en) begin
                // IDLE, or the edge that leaves RUN: outputs forced quiet.
                left_chan  <= '0;
                right_chan <= '0;
                chan_valid <= 1'b0;
                cur_src    <= 3'd0;
            end else if (xfer) begin
                left_chan  <= win_left;
                right_chan <= win_right;
                chan_valid <= 1'b1;
                cur_src    <= win_idx;
                ptr        <= win_idx;
                if (win_idx == ptr)
                    burst_cnt <= (burst_cnt == 4'hF) ? burst_cnt : burst_cnt + 4'd1;
                else
                    burst_cnt <= 4'd1;
            end else begin
                chan_valid <= 1'b0;
                burst_cnt  <= 4'd0;
                if (!UNDERRUN_HOLD) begin
                    left_chan  <= '0;
                    right_chan <= '0;
                end
            end

            if (clr_stats)
                underrun_cnt <= '0;
            else if (underrun && underrun_cnt != {UCNT_W{1'b1}})
                underrun_cnt <= underrun_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_i2s_frame_arbiter.sv
module tb_i2s_frame_arbiter;

    localparam int DW = 32;
    localparam int NS = 4;

    typedef struct {
        bit         rb;    // pulse async reset before this vector
        bit         en;
        bit         md;
        bit         clr;
        bit [3:0]   vld;
        bit [3:0]   rdy;   // expected src_ready before the edge
        bit         cvld;
        bit [2:0]   cur;
        bit         dz;    // HOLD=0 instance outputs zero
        bit         hz;    // HOLD=1 instance outputs zero
        bit [15:0]  ucnt;
    } vec_t;

    logic            lrclk = 1'b0;
    logic            rst;
    logic            enable;
    logic            mode;
    logic            clr_stats;
    logic [NS-1:0]   src_valid;
    logic [NS*DW-1:0] src_left;
    logic [NS*DW-1:0] src_right;

    logic [NS-1:0]   rdy0, rdy1;
    logic [DW-1:0]   l0, r0, l1, r1;
    logic            cv0, cv1;
    logic [2:0]      cs0, cs1;
    logic [15:0]     uc0, uc1;

    logic [DW-1:0] lt [NS] = '{32'h01234567, 32'h11110001, 32'h22220002, 32'h33330003};
    logic [DW-1:0] rt [NS] = '{32'h89abcdef, 32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003};

    int n_chk = 0;
    int n_err = 0;

    vec_t vt [24];

    always #5 lrclk = ~lrclk;

    always_comb begin
        for (int i = 0; i < NS; i++) begin
            src_left[i*DW +: DW]  = lt[i];
            src_right[i*DW +: DW] = rt[i];
        end
    end

    i2s_frame_arbiter #(.AUDIO_DW(DW), .NUM_SRC(NS), .BURST(2), .UNDERRUN_HOLD(1'b0)) dut0 (
        .lrclk(lrclk), .rst(rst), .enable(enable), .mode(mode), .clr_stats(clr_stats),
        .src_valid(src_valid), .src_left(src_left), .src_right(src_right),
        .src_ready(rdy0), .left_chan(l0), .right_chan(r0), .chan_valid(cv0),
        .cur_src(cs0), .underrun_cnt(uc0));

    i2s_frame_arbiter #(.AUDIO_DW(DW), .NUM_SRC(NS), .BURST(2), .UNDERRUN_HOLD(1'b1)) dut1 (
        .lrclk(lrclk), .rst(rst), .enable(enable), .mode(mode), .clr_stats(clr_stats),
        .src_valid(src_valid), .src_left(src_left), .src_right(src_right),
        .src_ready(rdy1), .left_chan(l1), .right_chan(r1), .chan_valid(cv1),
        .cur_src(cs1), .underrun_cnt(uc1));

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    initial begin
        // rb en md clr vld     rdy     cvld cur  dz hz ucnt
        vt[0]  = '{0, 1, 0, 0, 4'b0001, 4'b0000, 0, 3'd0, 1, 1, 16'd0}; // IDLE->RUN
        vt[1]  = '{0, 1, 0, 0, 4'b0001, 4'b0001, 1, 3'd0, 0, 0, 16'd0};
        vt[2]  = '{0, 1, 0, 0, 4'b1111, 4'b0001, 1, 3'd0, 0, 0, 16'd0}; // RR burst
        vt[3]  = '{0, 1, 0, 0, 4'b1111, 4'b0010, 1, 3'd1, 0, 0, 16'd0};
        vt[4]  = '{0, 1, 0, 0, 4'b1111, 4'b0010, 1, 3'd1, 0, 0, 16'd0};
        vt[5]  = '{0, 1, 0, 0, 4'b1111, 4'b0100, 1, 3'd2, 0, 0, 16'd0};
        vt[6]  = '{0, 1, 0, 0, 4'b1111, 4'b0100, 1, 3'd2, 0, 0, 16'd0};
        vt[7]  = '{0, 1, 0, 0, 4'b1111, 4'b1000, 1, 3'd3, 0, 0, 16'd0};
        vt[8]  = '{0, 1, 0, 0, 4'b1111, 4'b1000, 1, 3'd3, 0, 0, 16'd0};
        vt[9]  = '{0, 1, 0, 0, 4'b1111, 4'b0001, 1, 3'd0, 0, 0, 16'd0};
        vt[10] = '{0, 1, 1, 0, 4'b1010, 4'b0010, 1, 3'd1, 0, 0, 16'd0}; // fixed prio
        vt[11] = '{0, 1, 1, 0, 4'b1010, 4'b0010, 1, 3'd1, 0, 0, 16'd0};
        vt[12] = '{0, 1, 1, 0, 4'b1010, 4'b0010, 1, 3'd1, 0, 0, 16'd0};
        vt[13] = '{0, 1, 1, 0, 4'b1000, 4'b1000, 1, 3'd3, 0, 0, 16'd0};
        vt[14] = '{0, 1, 0, 0, 4'b0000, 4'b0000, 0, 3'd3, 1, 0, 16'd1}; // underrun
        vt[15] = '{0, 1, 0, 0, 4'b0000, 4'b0000, 0, 3'd3, 1, 0, 16'd2};
        vt[16] = '{0, 1, 0, 0, 4'b0000, 4'b0000, 0, 3'd3, 1, 0, 16'd3};
        vt[17] = '{0, 1, 0, 1, 4'b0000, 4'b0000, 0, 3'd3, 1, 0, 16'd0}; // clr wins
        vt[18] = '{0, 1, 0, 0, 4'b0100, 4'b0100, 1, 3'd2, 0, 0, 16'd0};
        vt[19] = '{0, 0, 0, 0, 4'b0100, 4'b0000, 0, 3'd0, 1, 1, 16'd0}; // disable
        vt[20] = '{0, 1, 0, 0, 4'b0100, 4'b0000, 0, 3'd0, 1, 1, 16'd0}; // empty edge
        vt[21] = '{0, 1, 0, 0, 4'b0100, 4'b0100, 1, 3'd2, 0, 0, 16'd0};
        vt[22] = '{1, 1, 0, 0, 4'b1111, 4'b0000, 0, 3'd0, 1, 1, 16'd0}; // after reset
        vt[23] = '{0, 1, 0, 0, 4'b1111, 4'b0001, 1, 3'd0, 0, 0, 16'd0};

        rst       = 1'b0;
        enable    = 1'b0;
        mode      = 1'b0;
        clr_stats = 1'b0;
        src_valid = '0;
        #12;
        check("reset_left", -1, l0, 32'd0);
        check("reset_cvld", -1, {31'd0, cv0}, 32'd0);
        check("reset_cur", -1, {29'd0, cs0}, 32'd0);
        check("reset_ucnt", -1, {16'd0, uc0}, 32'd0);
        check("reset_ready", -1, {28'd0, rdy0}, 32'd0);
        @(negedge lrclk);
        rst = 1'b1;

        for (int i = 0; i < 24; i++) begin
            @(negedge lrclk);
            if (vt[i].rb) begin
                // Async reset between edges, checked before the next edge.
                #1 rst = 1'b0;
                #1;
                check("async_left", i, l0, 32'd0);
                check("async_cvld", i, {31'd0, cv0}, 32'd0);
                check("async_cur", i, {29'd0, cs0}, 32'd0);
                #1 rst = 1'b1;
            end
            enable    = vt[i].en;
            mode      = vt[i].md;
            clr_stats = vt[i].clr;
            src_valid = vt[i].vld;
            #1;
            check("ready", i, {28'd0, rdy0}, {28'd0, vt[i].rdy});
            @(posedge lrclk);
            #1;
            check("cvld", i, {31'd0, cv0}, {31'd0, vt[i].cvld});
            check("cur", i, {29'd0, cs0}, {29'd0, vt[i].cur});
            check("left", i, l0, vt[i].dz ? 32'd0 : lt[vt[i].cur]);
            check("right", i, r0, vt[i].dz ? 32'd0 : rt[vt[i].cur]);
            check("ucnt", i, {16'd0, uc0}, {16'd0, vt[i].ucnt});
            check("hold_left", i, l1, vt[i].hz ? 32'd0 : lt[vt[i].cur]);
            check("hold_right", i, r1, vt[i].hz ? 32'd0 : rt[vt[i].cur]);
            check("hold_cvld", i, {31'd0, cv1}, {31'd0, vt[i].cvld});
        end

        // Counter saturation: 65535 underrun frames then a few more.
        @(negedge lrclk);
        clr_stats = 1'b0;
        src_valid = '0;
        repeat (65535) @(posedge lrclk);
        #1;
        check("sat_reach", 0, {16'd0, uc0}, 32'h0000FFFF);
        repeat (3) @(posedge lrclk);
        #1;
        check("sat_stay", 0, {16'd0, uc0}, 32'h0000FFFF);
        check("sat_stay_hold", 0, {16'd0, uc1}, 32'h0000FFFF);
        check("sat_hold_left", 0, l1, lt[0]);
        @(negedge lrclk);
        clr_stats = 1'b1;
        @(posedge lrclk);
        #1;
        check("sat_clr", 0, {16'd0, uc0}, 32'd0);
        @(negedge lrclk);
        clr_stats = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
